// File: rtl/ram_rw_arbiter.sv
// rtl/ram_rw_arbiter.sv - single-port RAM arbiter between IFU reads and LSU reads/writes
module ram_rw_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_i,
  input  logic [AW-1:0]     ifu_addr_i,
  output logic              ifu_resp_valid_o,
  output logic [DW-1:0]     ifu_rdata_o,
  output logic              ifu_err_o,
  input  logic              lsu_req_i,
  input  logic              lsu_wen_i,
  input  logic [AW-1:0]     lsu_addr_i,
  input  logic [DW-1:0]     lsu_wdata_i,
  input  logic [DW/8-1:0]   lsu_wmask_i,
  input  logic [2:0]        lsu_size_i,
  output logic              lsu_resp_valid_o,
  output logic [DW-1:0]     lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [AW-1:0]     ram_addr_o,
  output logic [DW-1:0]     ram_wdata_o,
  output logic [DW/8-1:0]   ram_wmask_o,
  output logic [2:0]        ram_size_o,
  input  logic              ram_ready_i,
  input  logic [DW-1:0]     ram_rdata_i
);

  localparam int MW = DW / 8;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} own_t;

  state_t          state_q;
  own_t            own_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   wait_q;

  // Fields captured at grant, replayed on the RAM port in ISSUE.
  logic            lat_wen_q;
  logic [AW-1:0]   lat_addr_q;
  logic [DW-1:0]   lat_wdata_q;
  logic [MW-1:0]   lat_wmask_q;
  logic [2:0]      lat_size_q;

  logic            ram_cen_q, ram_wen_q;
  logic [AW-1:0]   ram_addr_q;
  logic [DW-1:0]   ram_wdata_q;
  logic [MW-1:0]   ram_wmask_q;
  logic [2:0]      ram_size_q;

  logic            ifu_resp_valid_q, ifu_err_q;
  logic [DW-1:0]   ifu_rdata_q;
  logic            lsu_resp_valid_q, lsu_err_q;
  logic [DW-1:0]   lsu_rdata_q;

  logic            grant_if, grant_ls;

  // Grant decision (LSU preferred unless the IFU has been starved) and starvation counter update.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      grant_if = ifu_req_i && (!lsu_req_i || (starve_q == SW'(STARVE_MAX)));
      grant_ls = lsu_req_i && !grant_if;
    end
    if (!ifu_req_i || grant_if) begin
      starve_d = '0;
    end else if (grant_ls && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Transaction FSM with registered RAM-side and requester-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      own_q            <= OWN_IF;
      starve_q         <= '0;
      wait_q           <= '0;
      lat_wen_q        <= 1'b0;
      lat_addr_q       <= '0;
      lat_wdata_q      <= '0;
      lat_wmask_q      <= '0;
      lat_size_q       <= '0;
      ram_cen_q        <= 1'b0;
      ram_wen_q        <= 1'b0;
      ram_addr_q       <= '0;
      ram_wdata_q      <= '0;
      ram_wmask_q      <= '0;
      ram_size_q       <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_err_q        <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_err_q        <= 1'b0;
      lsu_rdata_q      <= '0;
    end else begin
      ram_cen_q        <= 1'b0;
      ram_wen_q        <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      ifu_err_q        <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_err_q        <= 1'b0;
      starve_q         <= starve_d;
      case (state_q)
        S_IDLE: begin
          if (grant_if) begin
            own_q       <= OWN_IF;
            lat_wen_q   <= 1'b0;
            lat_addr_q  <= ifu_addr_i;
            lat_wdata_q <= '0;
            lat_wmask_q <= '0;
            lat_size_q  <= 3'd3;
            state_q     <= S_ISSUE;
          end else if (grant_ls) begin
            own_q       <= OWN_LS;
            lat_wen_q   <= lsu_wen_i;
            lat_addr_q  <= lsu_addr_i;
            lat_wdata_q <= lsu_wdata_i;
            lat_wmask_q <= lsu_wmask_i;
            lat_size_q  <= lsu_size_i;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_cen_q   <= 1'b1;
          ram_wen_q   <= lat_wen_q;
          ram_addr_q  <= lat_addr_q;
          ram_wdata_q <= lat_wdata_q;
          ram_wmask_q <= lat_wmask_q;
          ram_size_q  <= lat_size_q;
          wait_q      <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // Ready wins over a coinciding timeout.
          if (ram_ready_i) begin
            if (own_q == OWN_IF) begin
              ifu_resp_valid_q <= 1'b1;
              ifu_rdata_q      <= ram_rdata_i;
            end else begin
              lsu_resp_valid_q <= 1'b1;
              if (!lat_wen_q) begin
                lsu_rdata_q <= ram_rdata_i;
              end
            end
            wait_q  <= '0;
            state_q <= S_IDLE;
          end else if (wait_q == TW'(TIMEOUT - 1)) begin
            if (own_q == OWN_IF) begin
              ifu_resp_valid_q <= 1'b1;
              ifu_err_q        <= 1'b1;
            end else begin
              lsu_resp_valid_q <= 1'b1;
              lsu_err_q        <= 1'b1;
            end
            wait_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ifu_resp_valid_o = ifu_resp_valid_q;
  assign ifu_rdata_o      = ifu_rdata_q;
  assign ifu_err_o        = ifu_err_q;
  assign lsu_resp_valid_o = lsu_resp_valid_q;
  assign lsu_rdata_o      = lsu_rdata_q;
  assign lsu_err_o        = lsu_err_q;
  assign ram_cen_o        = ram_cen_q;
  assign ram_wen_o        = ram_wen_q;
  assign ram_addr_o       = ram_addr_q;
  assign ram_wdata_o      = ram_wdata_q;
  assign ram_wmask_o      = ram_wmask_q;
  assign ram_size_o       = ram_size_q;

endmodule
